// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared constants, state type and access legality helper
//               for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // RV32 width/sign codes carried in funct3
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // Completion codes reported on resp_err
  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } lsu_state_t;

  // True when the access is misaligned for its width or uses a funct3
  // that is not defined for its direction (unsigned stores, codes 3/6/7).
  function automatic logic access_bad(input logic       is_store,
                                      input logic [2:0] f3,
                                      input logic [1:0] off);
    logic bad;
    bad = 1'b1;
    case (f3)
      F3_B:    bad = 1'b0;
      F3_BU:   bad = is_store;
      F3_H:    bad = off[0];
      F3_HU:   bad = is_store | off[0];
      F3_W:    bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane formatter. In store mode it replicates
//               the right-justified data across the byte lanes and builds
//               the byte-write mask; in load mode it picks the addressed
//               lane and sign/zero-extends it, reporting the lanes read.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic [3:0]  we_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection and per-width formatting for either direction
  always_comb begin
    case (offset_i)
      2'd0:    w_byte = data_i[7:0];
      2'd1:    w_byte = data_i[15:8];
      2'd2:    w_byte = data_i[23:16];
      default: w_byte = data_i[31:24];
    endcase
    w_half = offset_i[1] ? data_i[31:16] : data_i[15:0];
    data_o = 32'h0;
    we_o   = 4'h0;
    if (is_store_i) begin
      case (funct3_i)
        F3_B: begin
          data_o = {4{data_i[7:0]}};
          we_o   = 4'b0001 << offset_i;
        end
        F3_H: begin
          data_o = {2{data_i[15:0]}};
          we_o   = 4'b0011 << offset_i;
        end
        F3_W: begin
          data_o = data_i;
          we_o   = 4'hF;
        end
        default: ;
      endcase
    end else begin
      case (funct3_i)
        F3_B: begin
          data_o = {{24{w_byte[7]}}, w_byte};
          we_o   = 4'b0001 << offset_i;
        end
        F3_BU: begin
          data_o = {24'h0, w_byte};
          we_o   = 4'b0001 << offset_i;
        end
        F3_H: begin
          data_o = {{16{w_half[15]}}, w_half};
          we_o   = 4'b0011 << offset_i;
        end
        F3_HU: begin
          data_o = {16'h0, w_half};
          we_o   = 4'b0011 << offset_i;
        end
        F3_W: begin
          data_o = data_i;
          we_o   = 4'hF;
        end
        default: ;
      endcase
    end
  end

endmodule : lsu_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Data-side access stage. Accepts one load/store at a time,
//               issues an aligned word request with byte enables to the IO
//               fabric, and returns extended load data or an error code.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_isRequest,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_din,
  input  logic [31:0] mem_dout,
  input  logic        mem_requestDone,
  input  logic        mem_readValid
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Last count value spent in REQ before the access is abandoned
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             st_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;

  logic             req_ready_q;
  logic             resp_valid_q;
  logic [31:0]      resp_rdata_q;
  logic [1:0]       resp_err_q;
  logic             mem_isRequest_q;
  logic [31:0]      mem_addr_q;
  logic [3:0]       mem_we_q;
  logic [31:0]      mem_din_q;

  logic [31:0]      w_st_data;
  logic [3:0]       w_st_we;
  logic [31:0]      w_ld_data;
  logic [3:0]       w_ld_lanes;
  logic             w_bad;
  logic [31:0]      w_rdata_d;

  // Store formatting straight from the incoming request fields
  lsu_align u_align_st (
    .is_store_i (1'b1),
    .funct3_i   (req_funct3),
    .offset_i   (req_addr[1:0]),
    .data_i     (req_wdata),
    .data_o     (w_st_data),
    .we_o       (w_st_we)
  );

  // Load extraction from the fabric data using the latched access fields
  lsu_align u_align_ld (
    .is_store_i (1'b0),
    .funct3_i   (f3_q),
    .offset_i   (off_q),
    .data_i     (mem_dout),
    .data_o     (w_ld_data),
    .we_o       (w_ld_lanes)
  );

  assign w_bad = access_bad(req_is_store, req_funct3, req_addr[1:0]);
  // Stores and loads without valid read data return zero
  assign w_rdata_d = (!st_q && mem_readValid && (w_ld_lanes != 4'h0)) ? w_ld_data : 32'h0;

  // Access sequencer with registered outputs and the request timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      st_q            <= 1'b0;
      f3_q            <= 3'd0;
      off_q           <= 2'd0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= 32'h0;
      resp_err_q      <= ERR_OK;
      mem_isRequest_q <= 1'b0;
      mem_addr_q      <= 32'h0;
      mem_we_q        <= 4'h0;
      mem_din_q       <= 32'h0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            st_q        <= req_is_store;
            f3_q        <= req_funct3;
            off_q       <= req_addr[1:0];
            mem_addr_q  <= {req_addr[31:2], 2'b00};
            req_ready_q <= 1'b0;
            if (w_bad) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= ERR_ALIGN;
              resp_rdata_q <= 32'h0;
              mem_we_q     <= 4'h0;
              mem_din_q    <= 32'h0;
            end else begin
              state_q         <= S_REQ;
              cnt_q           <= '0;
              mem_isRequest_q <= 1'b1;
              mem_we_q        <= req_is_store ? w_st_we : 4'h0;
              mem_din_q       <= req_is_store ? w_st_data : 32'h0;
            end
          end
        end
        S_REQ: begin
          // A completion in the expiry cycle still wins over the timeout
          if (mem_requestDone) begin
            state_q         <= S_RESP;
            mem_isRequest_q <= 1'b0;
            resp_valid_q    <= 1'b1;
            resp_err_q      <= ERR_OK;
            resp_rdata_q    <= w_rdata_d;
          end else if (cnt_q == C_CNT_LAST) begin
            state_q         <= S_RESP;
            mem_isRequest_q <= 1'b0;
            resp_valid_q    <= 1'b1;
            resp_err_q      <= ERR_TIMEOUT;
            resp_rdata_q    <= 32'h0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign mem_isRequest = mem_isRequest_q;
  assign mem_addr      = mem_addr_q;
  assign mem_we        = mem_we_q;
  assign mem_din       = mem_din_q;

endmodule : load_store_unit
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic        mem_isRequest;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_requestDone;
  logic        mem_readValid;

  int n_vec;
  int n_err;
  int cyc;
  int t_first;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_is_store    (req_is_store),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .mem_isRequest   (mem_isRequest),
    .mem_addr        (mem_addr),
    .mem_we          (mem_we),
    .mem_din         (mem_din),
    .mem_dout        (mem_dout),
    .mem_requestDone (mem_requestDone),
    .mem_readValid   (mem_readValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to the middle of the next cycle
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
  endtask

  // Legal access answered in cycle 1; checks request, response and ready
  task automatic access(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] dout, input logic rv,
                        input logic [3:0] exp_we, input logic [31:0] exp_din,
                        input logic [31:0] exp_rdata);
    drive(st, f3, a, wd);
    tick();
    req_valid = 1'b0;
    chk({tag, ".isreq"}, mem_isRequest, 1'b1);
    chk({tag, ".addr"},  mem_addr, {a[31:2], 2'b00});
    chk({tag, ".we"},    mem_we, exp_we);
    if (st) chk({tag, ".din"}, mem_din, exp_din);
    mem_requestDone = 1'b1;
    mem_readValid   = rv;
    mem_dout        = dout;
    tick();
    mem_requestDone = 1'b0;
    mem_readValid   = 1'b0;
    chk({tag, ".rvalid"}, resp_valid, 1'b1);
    chk({tag, ".err"},    resp_err, 2'd0);
    chk({tag, ".rdata"},  resp_rdata, exp_rdata);
    tick();
    chk({tag, ".ready"},  req_ready, 1'b1);
  endtask

  // Rejected access: response in cycle 1, no fabric request
  task automatic bad_access(input string tag, input logic st, input logic [2:0] f3, input logic [31:0] a);
    drive(st, f3, a, 32'h1111_2222);
    tick();
    req_valid = 1'b0;
    chk({tag, ".rvalid"}, resp_valid, 1'b1);
    chk({tag, ".err"},    resp_err, 2'd1);
    chk({tag, ".isreq"},  mem_isRequest, 1'b0);
    chk({tag, ".ready0"}, req_ready, 1'b0);
    tick();
    chk({tag, ".ready"},  req_ready, 1'b1);
    chk({tag, ".pulse"},  resp_valid, 1'b0);
  endtask

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0; mem_dout = 32'h0;
    mem_requestDone = 1'b0; mem_readValid = 1'b0;
    tick();
    tick();
    chk("rst.ready",  req_ready, 1'b1);
    chk("rst.rvalid", resp_valid, 1'b0);
    chk("rst.isreq",  mem_isRequest, 1'b0);
    chk("rst.we",     mem_we, 4'h0);
    chk("rst.addr",   mem_addr, 32'h0);
    chk("rst.err",    resp_err, 2'd0);
    rst_n = 1'b1;
    tick();

    // Store formatting
    access("sb", 1'b1, 3'd0, 32'h8000_0003, 32'h0000_00A5, 32'h0, 1'b0, 4'b1000, 32'hA5A5_A5A5, 32'h0);
    access("sh", 1'b1, 3'd1, 32'h0000_0102, 32'h1234_BEEF, 32'h0, 1'b0, 4'b1100, 32'hBEEF_BEEF, 32'h0);
    access("sw", 1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 4'b1111, 32'hDEAD_BEEF, 32'h0);

    // Load extraction and extension
    access("lb",  1'b0, 3'd0, 32'h8000_0002, 32'h0, 32'h12F3_4567, 1'b1, 4'h0, 32'h0, 32'hFFFF_FFF3);
    access("lbu", 1'b0, 3'd4, 32'h8000_0002, 32'h0, 32'h12F3_4567, 1'b1, 4'h0, 32'h0, 32'h0000_00F3);
    access("lhu", 1'b0, 3'd5, 32'h8000_0002, 32'h0, 32'h12F3_4567, 1'b1, 4'h0, 32'h0, 32'h0000_12F3);
    access("lh",  1'b0, 3'd1, 32'h8000_0000, 32'h0, 32'h12F3_8567, 1'b1, 4'h0, 32'h0, 32'hFFFF_8567);
    access("lb1", 1'b0, 3'd0, 32'h0000_0001, 32'h0, 32'h0000_7F00, 1'b1, 4'h0, 32'h0, 32'h0000_007F);
    access("lnrv", 1'b0, 3'd2, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 1'b0, 4'h0, 32'h0, 32'h0);

    // Misaligned / illegal
    bad_access("lw_mis", 1'b0, 3'd2, 32'h0000_0006);
    bad_access("ld_f3",  1'b0, 3'd3, 32'h0000_0000);
    bad_access("lh_odd", 1'b0, 3'd1, 32'h0000_0003);
    bad_access("st_f4",  1'b1, 3'd4, 32'h0000_0000);

    // Timeout with TIMEOUT_CYCLES = 4
    drive(1'b0, 3'd2, 32'h0000_0040, 32'h0);
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("to.isreq%0d", i), mem_isRequest, 1'b1);
      chk($sformatf("to.noresp%0d", i), resp_valid, 1'b0);
      tick();
    end
    chk("to.rvalid", resp_valid, 1'b1);
    chk("to.err",    resp_err, 2'd2);
    chk("to.isreq",  mem_isRequest, 1'b0);
    chk("to.rdata",  resp_rdata, 32'h0);
    tick();
    chk("to.ready",  req_ready, 1'b1);

    // Completion in the expiry cycle counts as success
    drive(1'b0, 3'd2, 32'h0000_0044, 32'h0);
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    chk("edge.isreq", mem_isRequest, 1'b1);
    mem_requestDone = 1'b1; mem_readValid = 1'b1; mem_dout = 32'h5555_AAAA;
    tick();
    mem_requestDone = 1'b0; mem_readValid = 1'b0;
    chk("edge.rvalid", resp_valid, 1'b1);
    chk("edge.err",    resp_err, 2'd0);
    chk("edge.rdata",  resp_rdata, 32'h5555_AAAA);
    tick();

    // Back-to-back SW then LW; LW held from the response cycle
    drive(1'b1, 3'd2, 32'h0000_0080, 32'h0BAD_F00D);
    tick();
    req_valid = 1'b0;
    mem_requestDone = 1'b1;
    tick();
    mem_requestDone = 1'b0;
    chk("b2b.sw_rvalid", resp_valid, 1'b1);
    t_first = cyc;
    drive(1'b0, 3'd2, 32'h0000_0080, 32'h0);
    tick();
    chk("b2b.ready",  req_ready, 1'b1);
    chk("b2b.ignore", mem_isRequest, 1'b0);
    tick();
    req_valid = 1'b0;
    chk("b2b.isreq", mem_isRequest, 1'b1);
    mem_requestDone = 1'b1; mem_readValid = 1'b1; mem_dout = 32'hCAFE_F00D;
    tick();
    mem_requestDone = 1'b0; mem_readValid = 1'b0;
    chk("b2b.lw_rvalid", resp_valid, 1'b1);
    chk("b2b.lw_rdata",  resp_rdata, 32'hCAFE_F00D);
    chk("b2b.spacing",   cyc - t_first, 32'd3);
    tick();

    // Reset while the request is outstanding
    drive(1'b0, 3'd2, 32'h0000_00C0, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("rmid.isreq", mem_isRequest, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rmid.drop",  mem_isRequest, 1'b0);
    chk("rmid.ready", req_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rmid.noresp%0d", i), resp_valid, 1'b0);
    end
    chk("rmid.ready_after", req_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_load_store_unit
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Data-side memory access stage between the core's execute/memory pipeline stage and port B of the memory-mapped IO fabric. It accepts one load or store per transaction from the core and formats RV32 byte/halfword/word accesses into aligned 32-bit requests with byte-write enables. It drives the fabric's isRequest/requestDone/readValid handshake and returns sign- or zero-extended load data. Misaligned or illegal accesses and unanswered requests complete with an error code instead of hanging the core.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles `mem_isRequest` stays high without `mem_requestDone` before the access is abandoned; 1..65535.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset; asserts immediately, release is synchronised externally.
- req_valid  in  1  core presents an access.
- req_ready  out  1  unit can accept an access; reset 1.
- req_is_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 width/sign code: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU (loads); 0/1/2 only for stores.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse; reset 0.
- resp_rdata  out  32  extended load data, valid with resp_valid; 0 for stores and errors; reset 0.
- resp_err  out  2  0 = ok, 1 = misaligned/illegal, 2 = timeout; reset 0.
- mem_isRequest  out  1  request to fabric; reset 0.
- mem_addr  out  32  word address {req_addr[31:2],2'b00}; reset 0.
- mem_we  out  4  byte write enables, 0 for loads; reset 0.
- mem_din  out  32  lane-replicated store data; reset 0.
- mem_dout  in  32  fabric read data.
- mem_requestDone  in  1  fabric finished the request.
- mem_readValid  in  1  mem_dout is valid; asserted only with mem_requestDone.

## Operation
- States: IDLE, REQ, RESP.
- IDLE: req_ready = 1. On req_valid, latch all req_* fields.
  - Misaligned or illegal access goes to RESP with err = 1. Misaligned means H/HU with addr[0] = 1, or W with addr[1:0] != 0. Illegal means load funct3 in {3,6,7} or store funct3 > 2.
  - Otherwise go to REQ.
- REQ: mem_isRequest = 1, and mem_addr/mem_we/mem_din are held stable. The timeout counter increments every cycle.
  - mem_requestDone = 1: capture mem_dout if the access is a load, then go to RESP with err = 0.
  - Counter reaches TIMEOUT_CYCLES: go to RESP with err = 2.
- RESP: resp_valid = 1 for exactly one cycle, req_ready = 0, then return to IDLE.
- Store formatting:
  - SB: mem_din = {4{wdata[7:0]}}, mem_we = 4'b0001 << addr[1:0].
  - SH: mem_din = {2{wdata[15:0]}}, mem_we = 4'b0011 << addr[1:0].
  - SW: mem_din = wdata, mem_we = 4'hF.
- Load extraction: select byte lane addr[1:0] or halfword lane addr[1], then sign-extend (B/H) or zero-extend (BU/HU).
- Load completes with mem_readValid = 0 while mem_requestDone = 1: treated as ok, with resp_rdata = 0.
- Only one outstanding access. req_valid is ignored outside IDLE.
- Reset mid-operation: all outputs drop to their reset values immediately, the in-flight access is discarded, and no response is issued.

## Timing
- Cycle 0: access accepted. Cycle 1: mem_isRequest high. Earliest mem_requestDone is in cycle 1. resp_valid follows mem_requestDone by exactly one cycle, so minimum accept-to-response latency is 2 cycles.
- Error path: accept in cycle 0, resp_valid in cycle 1, mem_isRequest never asserted.
- Timeout: with no mem_requestDone, mem_isRequest is high in cycles 1..TIMEOUT_CYCLES and resp_valid (err = 2) arrives in cycle TIMEOUT_CYCLES+1.
- Back-to-back: the next access can be accepted in the cycle after resp_valid. Maximum throughput is one access per 3 cycles.
- All outputs are registered. There is no combinational path from mem_* inputs to mem_* outputs.
- A mem_requestDone arriving in the same cycle the counter expires counts as success.

## Structure
- Shared package lsu_pkg holds:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU
  - resp_err codes ERR_OK/ERR_ALIGN/ERR_TIMEOUT
  - the state enum
- Sub-module lsu_align is combinational and used twice: store lane replication plus mem_we, and load lane extraction plus extension.
- Top level holds the FSM, the field latches and the timeout counter (width sized by TIMEOUT_CYCLES).

## Test plan
- SB of wdata = 0x000000A5 at 0x80000003 → mem_we = 4'b1000, mem_din = 0xA5A5A5A5, mem_addr = 0x80000000; resp_valid 1 cycle after mem_requestDone, err = 0.
- LB at 0x80000002 with mem_dout = 0x12F34567 → resp_rdata = 0xFFFFFFF3. LBU at the same address returns 0x000000F3. LHU at 0x80000002 returns 0x000012F3.
- LW at 0x00000006 → resp_valid in cycle 1 with err = 1 and mem_isRequest never high. Load with funct3 = 3 also gives err = 1.
- TIMEOUT_CYCLES = 4, no mem_requestDone → mem_isRequest high for 4 cycles, then resp_valid with err = 2 and req_ready = 1 the cycle after.
- SW then LW back-to-back with mem_requestDone in cycle 1 each time → responses 3 cycles apart, and the LW returns the mem_dout value.
- rst_n asserted while in REQ → mem_isRequest = 0 immediately, no resp_valid, req_ready = 1 after release.
